wb_cfg_master: RTL and testbench
================================

WB_CFG_MASTER -- requirements
Module: wb_cfg_master

Interface
REQ-001 Parameter ADR_W, 32, Wishbone address width.
REQ-002 Parameter DAT_W, 32, Wishbone data width.
REQ-003 Parameter TIMEOUT, 255, maximum number of BUS cycles without ACK_I/ERR_I before abort.
REQ-004 Ports SHALL be:
- CLK_I  in  1  single clock; all logic rising-edge.
- RST_I  in  1  asynchronous, active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  block accepts command.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  ADR_W  target address.
- req_dat  in  DAT_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_dat  out  DAT_W  read data; 0 for writes.
- rsp_err  out  1  completion by ERR_I or timeout.
- rsp_timeout  out  1  completion by timeout.
- CYC_O, STB_O, WE_O  out  1 each  Wishbone classic master strobes.
- ADR_O  out  ADR_W  bus address.
- DAT_O  out  DAT_W  bus write data.
- ACK_I, ERR_I  in  1 each  slave termination.
- DAT_I  in  DAT_W  slave read data.

Function
REQ-005 FSM states SHALL be IDLE, BUS, RESP; all bus and response outputs SHALL be registered.
REQ-006 IDLE: req_ready=1; a handshake (req_valid & req_ready) SHALL capture we/adr/dat and move to BUS.
REQ-007 Latency: handshake in cycle 0 -> CYC_O=STB_O=1, WE_O/ADR_O/DAT_O valid in cycle 1.
REQ-008 BUS: req_ready=0; CYC_O, STB_O, WE_O, ADR_O, DAT_O SHALL be held stable until termination.
REQ-009 ACK_I=1 sampled in BUS cycle k -> cycle k+1: CYC_O=STB_O=0, rsp_valid=1, rsp_err=0, rsp_dat=DAT_I sampled at k (read) or 0 (write); state RESP.
REQ-010 ERR_I=1 in BUS -> same as REQ-009 but rsp_err=1, rsp_dat=0.
REQ-011 ACK_I and ERR_I both high in the same cycle -> ERR_I wins.
REQ-012 Timeout counter SHALL clear on entering BUS and increment each BUS cycle; reaching TIMEOUT without termination -> abort as REQ-010 with rsp_timeout=1.
REQ-013 RESP lasts exactly one cycle (CYC_O low, req_ready 0), then IDLE; req_ready=1 in cycle k+2; a guaranteed minimum one idle bus cycle between transactions.
REQ-014 rsp_valid SHALL be a single-cycle pulse with no backpressure; rsp_* hold last value otherwise.
REQ-015 ACK_I/ERR_I outside BUS SHALL be ignored; outside BUS, WE_O=0, DAT_O=0, ADR_O=0.
REQ-016 req_* changes while req_ready=0 SHALL have no effect.

Reset
REQ-017 RST_I low SHALL immediately force state IDLE and all outputs 0, except req_ready, which SHALL be 0 during reset and 1 from the first edge after release.
REQ-018 Reset mid-BUS SHALL drop CYC_O/STB_O asynchronously with no rsp_valid pulse.

Structure
REQ-019 Package wb_cfg_pkg SHALL hold the FSM state enum and the default ADR_W/DAT_W/TIMEOUT constants.
REQ-020 Timeout counter SHALL be a sub-module wb_timeout_cnt (clear, enable, expired) sized $clog2(TIMEOUT+1).

Verification
REQ-021 Write 0x0/0x30201, slave ACKs after 3 cycles -> one CYC_O cycle run of length 4, rsp_valid with rsp_err=0, rsp_dat=0.
REQ-022 Read 0x4, slave ACKs cycle 2 with DAT_I=0xDEADBEEF -> rsp_dat=0xDEADBEEF, rsp_err=0.
REQ-023 No ACK, TIMEOUT=8 -> CYC_O drops after 8 BUS cycles, rsp_err=1, rsp_timeout=1.
REQ-024 ACK_I and ERR_I asserted together -> rsp_err=1, rsp_timeout=0.
REQ-025 RST_I pulled low 2 cycles into BUS -> CYC_O=0 immediately, no rsp_valid; next request completes normally.
REQ-026 100 back-to-back requests with random ACK delay 0-20 -> 100 rsp_valid pulses, CYC_O low at least one cycle between each.

Source files
------------

// File: rtl/wb_cfg_pkg.sv
// rtl/wb_cfg_pkg.sv - shared FSM state type and default sizing for the Wishbone config master
package wb_cfg_pkg;

    localparam int ADR_W_DEF   = 32;
    localparam int DAT_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - saturating bus-cycle counter that flags an unterminated access
module wb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The count is zero in the first bus cycle, so the last allowed cycle sees TIMEOUT-1.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q >= LIMIT);

    // Next count: clear wins, otherwise step while enabled and stop at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_cfg_master.sv
// rtl/wb_cfg_master.sv - single-outstanding Wishbone classic master driven by a valid/ready command port
module wb_cfg_master
    import wb_cfg_pkg::*;
#(
    parameter int ADR_W   = ADR_W_DEF,
    parameter int DAT_W   = DAT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ADR_W-1:0] req_adr,
    input  logic [DAT_W-1:0] req_dat,
    output logic             rsp_valid,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic             CYC_O,
    output logic             STB_O,
    output logic             WE_O,
    output logic [ADR_W-1:0] ADR_O,
    output logic [DAT_W-1:0] DAT_O,
    input  logic             ACK_I,
    input  logic             ERR_I,
    input  logic [DAT_W-1:0] DAT_I
);

    state_e           state_q, state_d;
    logic             ready_q, ready_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_to_q, rsp_to_d;
    logic             tmo_clr;
    logic             tmo_en;
    logic             tmo_expired;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (CLK_I),
        .rst_ni    (RST_I),
        .clear_i   (tmo_clr),
        .enable_i  (tmo_en),
        .expired_o (tmo_expired)
    );

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        cyc_d       = 1'b0;
        we_d        = 1'b0;
        adr_d       = '0;
        dat_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        tmo_clr     = 1'b0;
        tmo_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    state_d = ST_BUS;
                    ready_d = 1'b0;
                    cyc_d   = 1'b1;
                    we_d    = req_we;
                    adr_d   = req_adr;
                    dat_d   = req_dat;
                    tmo_clr = 1'b1;
                end
            end

            ST_BUS: begin
                tmo_en = 1'b1;
                // Error outranks acknowledge, and a real termination outranks the timeout.
                if (ERR_I) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b0;
                end else if (ACK_I) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : DAT_I;
                    rsp_err_d   = 1'b0;
                    rsp_to_d    = 1'b0;
                end else if (tmo_expired) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                end else begin
                    cyc_d = 1'b1;
                    we_d  = we_q;
                    adr_d = adr_q;
                    dat_d = dat_q;
                end
            end

            ST_RESP: begin
                // One dead bus cycle; the command port reopens on the next cycle.
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything, including req_ready.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign req_ready   = ready_q;
    assign CYC_O       = cyc_q;
    assign STB_O       = cyc_q;
    assign WE_O        = we_q;
    assign ADR_O       = adr_q;
    assign DAT_O       = dat_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_dat     = rsp_dat_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_wb_cfg_master.sv
// tb/tb_wb_cfg_master.sv - scoreboard bench for wb_cfg_master
module tb_wb_cfg_master;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int TMO   = 8;

    logic             CLK_I = 1'b0;
    logic             RST_I;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [ADR_W-1:0] req_adr;
    logic [DAT_W-1:0] req_dat;
    logic             rsp_valid;
    logic [DAT_W-1:0] rsp_dat;
    logic             rsp_err;
    logic             rsp_timeout;
    logic             CYC_O, STB_O, WE_O;
    logic [ADR_W-1:0] ADR_O;
    logic [DAT_W-1:0] DAT_O;
    logic             ACK_I, ERR_I;
    logic [DAT_W-1:0] DAT_I;

    wb_cfg_master #(
        .ADR_W   (ADR_W),
        .DAT_W   (DAT_W),
        .TIMEOUT (TMO)
    ) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_adr     (req_adr),
        .req_dat     (req_dat),
        .rsp_valid   (rsp_valid),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .CYC_O       (CYC_O),
        .STB_O       (STB_O),
        .WE_O        (WE_O),
        .ADR_O       (ADR_O),
        .DAT_O       (DAT_O),
        .ACK_I       (ACK_I),
        .ERR_I       (ERR_I),
        .DAT_I       (DAT_I)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          rsp_cnt = 0;
    int          sl_delay = 0;
    int          sl_mode = 3;      // 0 ack, 1 err, 2 ack+err, 3 silent
    int          sl_n = 0;
    logic [31:0] sl_rdata = '0;
    logic        stray_ack = 1'b0;
    int          run_len = 0;
    int          last_run = 0;
    logic        in_txn = 1'b0;
    logic        cur_we = 1'b0;
    logic [31:0] cur_adr = '0;
    logic [31:0] cur_dat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: terminates the access sl_delay cycles after CYC rises.
    initial begin
        ACK_I = 1'b0;
        ERR_I = 1'b0;
        DAT_I = '0;
        forever begin
            @(negedge CLK_I);
            ACK_I = 1'b0;
            ERR_I = 1'b0;
            DAT_I = 32'hBAD0_0000;
            if (CYC_O && STB_O) begin
                if (sl_n == sl_delay) begin
                    case (sl_mode)
                        0: begin ACK_I = 1'b1; DAT_I = sl_rdata; end
                        1: ERR_I = 1'b1;
                        2: begin ACK_I = 1'b1; ERR_I = 1'b1; DAT_I = sl_rdata; end
                        default: ;
                    endcase
                end
                sl_n++;
            end else begin
                sl_n  = 0;
                ACK_I = stray_ack;
                ERR_I = stray_ack;
            end
        end
    end

    // Monitor: bus stability, idle bus values, CYC run length and response scoreboard.
    initial begin
        rsp_t e;
        forever begin
            @(negedge CLK_I);
            if (CYC_O) begin
                run_len++;
                if (in_txn) begin
                    check("adr_hold", ADR_O, cur_adr);
                    check("we_hold", {31'd0, WE_O}, {31'd0, cur_we});
                    check("dat_hold", DAT_O, cur_dat);
                    check("stb_with_cyc", {31'd0, STB_O}, 32'd1);
                end
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
                check("idle_adr", ADR_O, 32'd0);
                check("idle_dat", DAT_O, 32'd0);
                check("idle_we_stb", {30'd0, WE_O, STB_O}, 32'd0);
            end
            if (rsp_valid) begin
                rsp_cnt++;
                check("rsp_cyc_low", {31'd0, CYC_O}, 32'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 required no pending request");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_dat", rsp_dat, e.dat);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
                end
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge CLK_I); #1;
            guard++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_wait: got req_ready=0 required 1 within 50 cycles");
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [31:0] rdata, input int delay, input int mode);
        rsp_t e;
        int   exp_run;
        int   n0;
        int   guard = 0;
        sl_delay = delay;
        sl_mode  = mode;
        sl_rdata = rdata;
        wait_ready();
        if (mode == 3 || delay >= TMO) begin
            e = '{dat: 32'd0, err: 1'b1, to: 1'b1};
            exp_run = TMO;
        end else if (mode == 0) begin
            e = '{dat: (we ? 32'd0 : rdata), err: 1'b0, to: 1'b0};
            exp_run = delay + 1;
        end else begin
            e = '{dat: 32'd0, err: 1'b1, to: 1'b0};
            exp_run = delay + 1;
        end
        exp_q.push_back(e);
        cur_we  = we;
        cur_adr = adr;
        cur_dat = dat;
        in_txn  = 1'b1;
        n0 = rsp_cnt;
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_dat   = dat;
        @(negedge CLK_I); #1;
        check("latency_cyc", {31'd0, CYC_O}, 32'd1);
        check("latency_adr", ADR_O, adr);
        check("ready_low_in_bus", {31'd0, req_ready}, 32'd0);
        // Junk on the command port while it is closed must not disturb the access.
        req_we  = ~we;
        req_adr = ~adr;
        req_dat = ~dat;
        while (rsp_cnt == n0 && guard < 60) begin
            @(negedge CLK_I); #1;
            guard++;
        end
        req_valid = 1'b0;
        in_txn    = 1'b0;
        if (rsp_cnt == n0) begin
            tests++;
            fails++;
            $display("FAIL rsp_wait: got no rsp_valid required one within 60 cycles");
        end else begin
            check("cyc_run_len", last_run, exp_run);
        end
    endtask

    initial begin
        int n0;
        RST_I     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_adr   = '0;
        req_dat   = '0;
        #2;
        check("rst_cyc", {31'd0, CYC_O}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_adr", ADR_O, 32'd0);
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, req_ready}, 32'd0);
        @(negedge CLK_I); #1;
        check("ready_after_edge", {31'd0, req_ready}, 32'd1);

        do_req(1'b1, 32'h0, 32'h0003_0201, 32'h0, 3, 0);
        do_req(1'b0, 32'h4, 32'h0, 32'hDEAD_BEEF, 2, 0);
        do_req(1'b0, 32'h8, 32'h0, 32'h1111_1111, 0, 3);
        do_req(1'b0, 32'hC, 32'h0, 32'h1234_5678, TMO - 1, 0);
        do_req(1'b0, 32'h10, 32'h0, 32'h8765_4321, TMO, 0);
        do_req(1'b1, 32'h14, 32'h55, 32'h0, 1, 1);
        do_req(1'b0, 32'h18, 32'h0, 32'hCAFE_F00D, 0, 2);
        do_req(1'b0, 32'h1C, 32'h0, 32'hA5A5_5A5A, 0, 0);

        // Terminations while idle must be ignored.
        n0 = rsp_cnt;
        stray_ack = 1'b1;
        repeat (3) @(negedge CLK_I);
        #1;
        stray_ack = 1'b0;
        @(negedge CLK_I); #1;
        check("stray_ack_ignored", rsp_cnt - n0, 32'd0);

        // Reset two cycles into a bus access.
        sl_mode = 3;
        wait_ready();
        n0 = rsp_cnt;
        cur_we = 1'b0; cur_adr = 32'h40; cur_dat = 32'h0; in_txn = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h40; req_dat = 32'h0;
        @(negedge CLK_I); #1;
        req_valid = 1'b0;
        @(negedge CLK_I); #1;
        check("pre_rst_cyc", {31'd0, CYC_O}, 32'd1);
        RST_I = 1'b0;
        #1;
        check("async_rst_cyc", {31'd0, CYC_O}, 32'd0);
        check("async_rst_stb", {31'd0, STB_O}, 32'd0);
        check("async_rst_ready", {31'd0, req_ready}, 32'd0);
        check("async_rst_rsp", {31'd0, rsp_valid}, 32'd0);
        in_txn = 1'b0;
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b1;
        @(negedge CLK_I); #1;
        check("no_rsp_after_rst", rsp_cnt - n0, 32'd0);
        do_req(1'b0, 32'h20, 32'h0, 32'h1122_3344, 1, 0);

        n0 = rsp_cnt;
        for (int i = 0; i < 100; i++) begin
            do_req(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 20)), 0);
        end
        check("burst_rsp_count", rsp_cnt - n0, 32'd100);

        repeat (3) @(negedge CLK_I);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog");
    end

endmodule
